score_display: RTL and testbench
================================

Name: score_display

Overview:
- Display-side consumer of the four BCD score digits from the score counter (big1/sm1 for player 1, big2/sm2 for player 2).
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display, one digit at a time.
- Snapshots the inputs once per scan frame so the display never shows a torn value.
- Flashes a player's digits for a fixed number of frames when that player's score changes.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit. One frame = 4*REFRESH_DIV cycles.
- FLASH_FRAMES, 64: frames a player's digits flash after that player's score changes. Range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- big1  in  4  player 1 tens digit, BCD
- sm1  in  4  player 1 units digit, BCD
- big2  in  4  player 2 tens digit, BCD
- sm2  in  4  player 2 units digit, BCD
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
- an  out  4  digit anodes, active-low, one-hot-low, registered
- dp  out  1  decimal point, active-low, registered

Behaviour:
- Reset, synchronous and active-high. On reset:
  - seg=7'h7F, an=4'hF, dp=1.
  - Refresh counter=0, scan index=0.
  - Shadow digits all 0; flash counters flash1=flash2=0.
- Reset mid-scan takes effect on the next clk edge and returns the block to this state.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap edge ("tick") the scan index advances 0→1→2→3→0.
- Scan map (index → an, digit shown):
  - 0 → 4'b1110, sm2
  - 1 → 4'b1101, big2
  - 2 → 4'b1011, sm1
  - 3 → 4'b0111, big1
- dp=0 only while index=2, marking the player separator. dp=1 otherwise.
- Outputs are registered from the current index and shadow state. an/seg/dp change exactly 1 cycle after the index changes.
- Frame boundary = a tick with index 3→0. On that edge:
  - All four inputs are latched into the shadow registers.
  - Inputs are ignored at every other time. Input-to-display latency is at most 4*REFRESH_DIV+1 cycles.
- Change detect, evaluated at the frame boundary:
  - If {big1,sm1} differs from shadow player 1, load flash1=FLASH_FRAMES.
  - Else, if flash1≠0, decrement flash1.
  - Same rule for player 2 with flash2.
  - The two players are independent; simultaneous changes load both counters.
  - A change while a counter is nonzero reloads it to FLASH_FRAMES.
- Flash blanking:
  - While flashN≠0 and flashN[2]==1, that player's two digits drive seg=7'h7F.
  - an still scans normally, and dp is unaffected.
- Segment decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Any value 10..15 displays a dash, 0111111.
- The block does not arithmetically validate BCD beyond this dash rule.
- No width growth; all counters saturate or wrap only as stated above.

Optional Feature:
- Macro LEAD_ZERO_BLANK_EN.
- Defined: when a player's shadow tens digit is 0, that digit position drives seg=7'h7F. The anode still scans and dp is unchanged. Example: score 07 shows " 7".
- Not defined: tens digit 0 displays as "0".
- Flash blanking applies on top of the feature in both cases.

Test Plan:
- Reset with REFRESH_DIV=4 and all inputs 0. Required: an=1111, seg=7F, dp=1 during reset. After release, an cycles 1110,1101,1011,0111 every 4 cycles, seg=1000000 on every digit, dp=0 only while an=1011.
- Set big1=1, sm1=2, big2=3, sm2=4 mid-frame. Required: display unchanged until the next frame boundary. The following frame shows seg 1111001 on an=0111, 0100100 on an=1011, 0110000 on an=1101, 0011001 on an=1110.
- Increment sm1 once, FLASH_FRAMES=8. Required: player 1 digits blank for frames where flash1∈{7,6,5,4} and are lit otherwise. After 8 frames they are steady lit. Player 2 digits never blank.
- Change both players in the same frame. Required: flash1=flash2=FLASH_FRAMES, and blanking is in phase for both. A change to player 1 only, 3 frames later, reloads flash1 only.
- Drive sm2=4'hC. Required: seg=0111111 on an=1110.
- Assert reset for 1 cycle while index=2 and flash1=5. Required: next cycle an=1111 and seg=7F, then the scan restarts at index 0 with no flashing. With LEAD_ZERO_BLANK_EN defined and big2=0, sm2=7, an=1101 shows seg=7F and an=1110 shows 1111000.

Source files
------------

// File: rtl/score_display.sv
// Four-digit multiplexed score display: per-frame input snapshot, per-player change flashing.
// Optional leading-zero blanking of each player's tens digit: define LEAD_ZERO_BLANK_EN.

module score_display_player #(
    parameter int FLASH_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame,
    input  logic [7:0] digits,
    output logic [7:0] shadow,
    output logic       blank
);
    logic [7:0] flash;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            flash  <= '0;
        end else if (frame) begin
            shadow <= digits;
            if (digits != shadow)
                flash <= 8'(FLASH_FRAMES);
            else if (flash != 8'd0)
                flash <= flash - 8'd1;
        end
    end

    // Blink with a 4-frame half-period taken straight from the countdown.
    assign blank = (flash != 8'd0) && flash[2];
endmodule

module score_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int FLASH_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] big1,
    input  logic [3:0] sm1,
    input  logic [3:0] big2,
    input  logic [3:0] sm2,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic            tick, frame;
    logic [1:0][7:0] pin, psh;
    logic [1:0]      pblank;
    logic [3:0]      cur_digit, cur_an;
    logic            cur_blank;

    assign tick  = (cnt == CW'(REFRESH_DIV - 1));
    assign frame = tick && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Lane 0 is player 1, lane 1 is player 2; each byte is {tens, units}.
    assign pin[0] = {big1, sm1};
    assign pin[1] = {big2, sm2};

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_player
            score_display_player #(.FLASH_FRAMES(FLASH_FRAMES)) u_player (
                .clk    (clk),
                .reset  (reset),
                .frame  (frame),
                .digits (pin[p]),
                .shadow (psh[p]),
                .blank  (pblank[p])
            );
        end
    endgenerate

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b0;
        cur_an    = 4'hF;
        case (idx)
            2'd0: begin
                cur_digit = psh[1][3:0];
                cur_blank = pblank[1];
                cur_an    = 4'b1110;
            end
            2'd1: begin
                cur_digit = psh[1][7:4];
                cur_blank = pblank[1] || (LZB && psh[1][7:4] == 4'd0);
                cur_an    = 4'b1101;
            end
            2'd2: begin
                cur_digit = psh[0][3:0];
                cur_blank = pblank[0];
                cur_an    = 4'b1011;
            end
            default: begin
                cur_digit = psh[0][7:4];
                cur_blank = pblank[0] || (LZB && psh[0][7:4] == 4'd0);
                cur_an    = 4'b0111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= 7'h7F;
            an  <= 4'hF;
            dp  <= 1'b1;
        end else begin
            seg <= cur_blank ? 7'h7F : decode(cur_digit);
            an  <= cur_an;
            dp  <= (idx != 2'd2);
        end
    end
endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with REFRESH_DIV=4 (16-cycle frames) and FLASH_FRAMES=8.

module tb_score_display;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] big1, sm1, big2, sm2;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000, DASH = 7'b0111111, BL = 7'h7F;
`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [6:0] TZ = 7'h7F;
`else
    localparam logic [6:0] TZ = 7'b1000000;
`endif

    score_display #(.REFRESH_DIV(4), .FLASH_FRAMES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .big1  (big1),
        .sm1   (sm1),
        .big2  (big2),
        .sm2   (sm2),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Waits out one digit slot (4 cycles) and checks what it showed.
    task automatic digit_chk(input string tag, input int k, input logic [6:0] s);
        logic [3:0] exp_an;
        repeat (4) @(posedge clk);
        #1;
        exp_an = ~(4'b0001 << k);
        chk($sformatf("%s.d%0d.an", tag, k), {4'h0, an}, {4'h0, exp_an});
        chk($sformatf("%s.d%0d.seg", tag, k), {1'b0, seg}, {1'b0, s});
        chk($sformatf("%s.d%0d.dp", tag, k), {7'h0, dp}, {7'h0, (k != 2)});
    endtask

    // Expected segments in scan order: sm2, big2, sm1, big1.
    task automatic frame_chk(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
        digit_chk(tag, 0, s0);
        digit_chk(tag, 1, s1);
        digit_chk(tag, 2, s2);
        digit_chk(tag, 3, s3);
    endtask

    initial begin
        reset = 1'b1;
        big1 = 4'd0; sm1 = 4'd0; big2 = 4'd0; sm2 = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.an", {4'h0, an}, 8'h0F);
        chk("rst.seg", {1'b0, seg}, 8'h7F);
        chk("rst.dp", {7'h0, dp}, 8'h01);
        reset = 1'b0;

        frame_chk("f0", S0, TZ, S0, TZ);

        // Inputs change mid-frame; the current frame must not show them.
        digit_chk("f1", 0, S0);
        digit_chk("f1", 1, TZ);
        big1 = 4'd1; sm1 = 4'd2; big2 = 4'd3; sm2 = 4'd4;
        digit_chk("f1", 2, S0);
        digit_chk("f1", 3, TZ);

        frame_chk("f2", S4, S3, S2, S1);      // both flash=8, lit
        frame_chk("f3", BL, BL, BL, BL);      // both flash=7

        digit_chk("f4", 0, BL);
        digit_chk("f4", 1, BL);
        sm1 = 4'd3;
        digit_chk("f4", 2, BL);
        digit_chk("f4", 3, BL);

        frame_chk("f5", BL, BL, S3, S1);      // flash1 reloaded to 8, flash2=5
        frame_chk("f6", BL, BL, BL, BL);      // 7 / 4
        frame_chk("f7", S4, S3, BL, BL);      // 6 / 3

        // Frame 8: flash1=5; reset lands while index 2 is on.
        digit_chk("f8", 0, S4);
        digit_chk("f8", 1, S3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2.an", {4'h0, an}, 8'h0F);
        chk("rst2.seg", {1'b0, seg}, 8'h7F);
        chk("rst2.dp", {7'h0, dp}, 8'h01);
        big1 = 4'd0; sm1 = 4'd5; big2 = 4'd0; sm2 = 4'hC;
        reset = 1'b0;

        frame_chk("r0", S0, TZ, S0, TZ);       // shadows cleared, no flashing
        digit_chk("r1", 0, DASH);
        digit_chk("r1", 1, TZ);
        sm2 = 4'd7;
        digit_chk("r1", 2, S5);
        digit_chk("r1", 3, TZ);
        frame_chk("r2", S7, TZ, BL, BL);      // flash2 reloaded, flash1=7

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
